// File: rtl/exe_flag_condition_pkg.sv
// Shared constants for the flag register and condition evaluation.
package exe_flag_condition_pkg;

    localparam int unsigned FLAG_W = 5;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned PC_W   = 2;

    // Flag bit positions in {ZF,PF,OF,SF,CF}
    localparam int unsigned FLAG_ZF = 4;
    localparam int unsigned FLAG_PF = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_SF = 1;
    localparam int unsigned FLAG_CF = 0;

    localparam logic [CODE_W-1:0] COND_AL = 4'd0;
    localparam logic [CODE_W-1:0] COND_EQ = 4'd1;
    localparam logic [CODE_W-1:0] COND_NE = 4'd2;
    localparam logic [CODE_W-1:0] COND_CS = 4'd3;
    localparam logic [CODE_W-1:0] COND_CC = 4'd4;
    localparam logic [CODE_W-1:0] COND_MI = 4'd5;
    localparam logic [CODE_W-1:0] COND_PL = 4'd6;
    localparam logic [CODE_W-1:0] COND_VS = 4'd7;
    localparam logic [CODE_W-1:0] COND_VC = 4'd8;
    localparam logic [CODE_W-1:0] COND_HI = 4'd9;
    localparam logic [CODE_W-1:0] COND_LS = 4'd10;
    localparam logic [CODE_W-1:0] COND_GE = 4'd11;
    localparam logic [CODE_W-1:0] COND_LT = 4'd12;
    localparam logic [CODE_W-1:0] COND_GT = 4'd13;
    localparam logic [CODE_W-1:0] COND_LE = 4'd14;
    localparam logic [CODE_W-1:0] COND_PE = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OUT
    } state_e;

endpackage

// File: rtl/exe_cond_eval.sv
// Combinational condition-code decode against a flag vector.
module exe_cond_eval
    import exe_flag_condition_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic [FLAG_W-1:0] flags,
    output logic              result_c
);

    logic zf, pf, of, sf, cf;

    assign zf = flags[FLAG_ZF];
    assign pf = flags[FLAG_PF];
    assign of = flags[FLAG_OF];
    assign sf = flags[FLAG_SF];
    assign cf = flags[FLAG_CF];

    always_comb begin
        result_c = 1'b0;
        case (code)
            COND_AL: result_c = 1'b1;
            COND_EQ: result_c = zf;
            COND_NE: result_c = !zf;
            COND_CS: result_c = cf;
            COND_CC: result_c = !cf;
            COND_MI: result_c = sf;
            COND_PL: result_c = !sf;
            COND_VS: result_c = of;
            COND_VC: result_c = !of;
            COND_HI: result_c = cf && !zf;
            COND_LS: result_c = !cf || zf;
            COND_GE: result_c = (sf == of);
            COND_LT: result_c = (sf != of);
            COND_GT: result_c = !zf && (sf == of);
            COND_LE: result_c = zf || (sf != of);
            COND_PE: result_c = pf;
            default: result_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_flag_condition.sv
// Flag register with pending-write tracking; resolves condition requests
// once all in-flight flag producers have written back.
module exe_flag_condition
    import exe_flag_condition_pkg::*;
#(
    parameter int unsigned P_PEND_MAX = 3
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iFLUSH,
    input  logic              iFLAG_PEND_SET,
    input  logic              iFLAG_WR_VALID,
    input  logic [FLAG_W-1:0] iFLAG_WR_DATA,
    input  logic              iCOND_VALID,
    input  logic [CODE_W-1:0] iCOND_CODE,
    output logic              oCOND_BUSY,
    output logic              oCOND_VALID,
    output logic              oCOND_RESULT,
    input  logic              iCOND_BUSY,
    output logic [FLAG_W-1:0] oFLAGS,
    output logic              oPEND_OVF
);

    localparam logic [PC_W-1:0] PEND_MAX = PC_W'(P_PEND_MAX);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              result_q, result_d;
    logic              busy_q, busy_d;

    logic [FLAG_W-1:0] eff_flags_c;
    logic [CODE_W-1:0] eval_code_c;
    logic              eval_result_c;
    logic [PC_W-1:0]   pc_next_c;

    // Idle evaluates the incoming code; otherwise the latched one
    assign eval_code_c = (state_q == ST_IDLE) ? iCOND_CODE : code_q;
    assign eff_flags_c = iFLAG_WR_VALID ? iFLAG_WR_DATA : flags_q;

    exe_cond_eval u_cond_eval (
        .code     (eval_code_c),
        .flags    (eff_flags_c),
        .result_c (eval_result_c)
    );

    always_comb begin
        flags_d   = flags_q;
        pc_next_c = pc_q;
        ovf_d     = ovf_q;
        state_d   = state_q;
        code_d    = code_q;
        result_d  = result_q;

        if (iFLAG_WR_VALID) begin
            flags_d = iFLAG_WR_DATA;
        end

        // Pending counter: saturates high (sticky overflow), clamps at zero
        if (iFLAG_PEND_SET && !iFLAG_WR_VALID) begin
            if (pc_q >= PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pc_next_c = pc_q + PC_W'(1);
            end
        end else if (iFLAG_WR_VALID && !iFLAG_PEND_SET && (pc_q != '0)) begin
            pc_next_c = pc_q - PC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (iCOND_VALID) begin
                    code_d = iCOND_CODE;
                    if (pc_next_c == '0) begin
                        result_d = eval_result_c;
                        state_d  = ST_OUT;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (pc_next_c == '0) begin
                    result_d = eval_result_c;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (!iCOND_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pc_d = pc_next_c;
        if (iFLUSH) begin
            state_d = ST_IDLE;
            pc_d    = '0;
            ovf_d   = ovf_q;
        end

        valid_d = (state_d == ST_OUT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            flags_q  <= '0;
            pc_q     <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            flags_q  <= flags_d;
            pc_q     <= pc_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign oCOND_BUSY   = busy_q;
    assign oCOND_VALID  = valid_q;
    assign oCOND_RESULT = result_q;
    assign oFLAGS       = flags_q;
    assign oPEND_OVF    = ovf_q;

endmodule

// File: tb/tb_exe_flag_condition.sv
// Directed-vector bench for exe_flag_condition with a queue-based result scoreboard.
module tb_exe_flag_condition;
    import exe_flag_condition_pkg::*;

    logic              iCLOCK;
    logic              inRESET;
    logic              iFLUSH;
    logic              iFLAG_PEND_SET;
    logic              iFLAG_WR_VALID;
    logic [FLAG_W-1:0] iFLAG_WR_DATA;
    logic              iCOND_VALID;
    logic [CODE_W-1:0] iCOND_CODE;
    logic              oCOND_BUSY;
    logic              oCOND_VALID;
    logic              oCOND_RESULT;
    logic              iCOND_BUSY;
    logic [FLAG_W-1:0] oFLAGS;
    logic              oPEND_OVF;

    exe_flag_condition #(.P_PEND_MAX(3)) dut (
        .iCLOCK         (iCLOCK),
        .inRESET        (inRESET),
        .iFLUSH         (iFLUSH),
        .iFLAG_PEND_SET (iFLAG_PEND_SET),
        .iFLAG_WR_VALID (iFLAG_WR_VALID),
        .iFLAG_WR_DATA  (iFLAG_WR_DATA),
        .iCOND_VALID    (iCOND_VALID),
        .iCOND_CODE     (iCOND_CODE),
        .oCOND_BUSY     (oCOND_BUSY),
        .oCOND_VALID    (oCOND_VALID),
        .oCOND_RESULT   (oCOND_RESULT),
        .iCOND_BUSY     (iCOND_BUSY),
        .oFLAGS         (oFLAGS),
        .oPEND_OVF      (oPEND_OVF)
    );

    typedef struct {
        logic  res;
        int    cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;
    always @(posedge iCLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected handshake cycle is relative to the cycle the request is driven in
    task automatic push(input logic r, input int lat, input string n);
        exp_t e;
        e.res  = r;
        e.cyc  = cyc + lat;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic drv(input logic fl, input logic ps, input logic wv, input logic [4:0] wd,
                       input logic cv, input logic [3:0] cc, input logic cb);
        iFLUSH         = fl;
        iFLAG_PEND_SET = ps;
        iFLAG_WR_VALID = wv;
        iFLAG_WR_DATA  = wd;
        iCOND_VALID    = cv;
        iCOND_CODE     = cc;
        iCOND_BUSY     = cb;
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Monitor: pops on each accepted result, flags unexpected or overdue outputs
    always @(negedge iCLOCK) begin
        if (inRESET === 1'b1) begin
            if (oCOND_VALID === 1'b1 && iCOND_BUSY === 1'b0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got valid=1 result=%0b expected no output (cycle %0d)",
                             oCOND_RESULT, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"}, 32'(oCOND_RESULT), 32'(e.res));
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                tests++;
                fails++;
                $display("FAIL %s_timeout: got no valid by cycle %0d expected at cycle %0d",
                         sb[0].name, cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        inRESET = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        idle();
        check("rst_flags", 32'(oFLAGS), 32'h0);
        check("rst_valid", 32'(oCOND_VALID), 32'h0);
        check("rst_result", 32'(oCOND_RESULT), 32'h0);
        check("rst_ovf", 32'(oPEND_OVF), 32'h0);
        check("rst_busy", 32'(oCOND_BUSY), 32'h0);
        inRESET = 1'b1;
        idle();

        // EQ / NE with PC=0
        drv(1'b0, 1'b0, 1'b1, 5'b10000, 1'b0, 4'd0, 1'b0);
        check("flags_wr", 32'(oFLAGS), 32'h10);
        push(1'b1, 1, "eq");
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_EQ, 1'b0);
        check("eq_busy", 32'(oCOND_BUSY), 32'h1);
        idle();
        push(1'b0, 1, "ne");
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_NE, 1'b0);
        idle();

        // LT waits for the pending write
        drv(1'b0, 1'b1, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_LT, 1'b0);
        check("lt_wait_busy", 32'(oCOND_BUSY), 32'h1);
        check("lt_wait_valid", 32'(oCOND_VALID), 32'h0);
        idle();
        check("lt_wait_valid2", 32'(oCOND_VALID), 32'h0);
        push(1'b1, 1, "lt");
        drv(1'b0, 1'b0, 1'b1, 5'b00010, 1'b0, 4'd0, 1'b0);
        idle();

        // Same-cycle write bypass with PC=1
        drv(1'b0, 1'b1, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        push(1'b1, 1, "cs_bypass");
        drv(1'b0, 1'b0, 1'b1, 5'b00001, 1'b1, COND_CS, 1'b0);
        check("bypass_flags", 32'(oFLAGS), 32'h01);
        idle();

        // Pending counter saturation and drain
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b1, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
            check("ovf_during_sets", 32'(oPEND_OVF), (i == 3) ? 32'h1 : 32'h0);
        end
        check("pc_sat", 32'(dut.pc_q), 32'h3);
        drv(1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 4'd0, 1'b0);
        check("pc_drain1", 32'(dut.pc_q), 32'h2);
        drv(1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 4'd0, 1'b0);
        check("pc_drain2", 32'(dut.pc_q), 32'h1);
        drv(1'b0, 1'b0, 1'b1, 5'b01000, 1'b0, 4'd0, 1'b0);
        check("pc_drain3", 32'(dut.pc_q), 32'h0);
        check("ovf_sticky", 32'(oPEND_OVF), 32'h1);
        push(1'b1, 1, "pe");
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_PE, 1'b0);
        idle();

        // Downstream stall holds the result; concurrent requests ignored
        push(1'b1, 4, "ge_stall");
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_GE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_EQ, 1'b1);
            check("stall_valid", 32'(oCOND_VALID), 32'h1);
            check("stall_result", 32'(oCOND_RESULT), 32'h1);
            check("stall_busy", 32'(oCOND_BUSY), 32'h1);
        end
        idle();
        check("stall_exit_valid", 32'(oCOND_VALID), 32'h0);
        check("stall_exit_busy", 32'(oCOND_BUSY), 32'h0);
        idle();

        // Flush while waiting with PC=2
        drv(1'b0, 1'b1, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_EQ, 1'b0);
        check("flush_pre_busy", 32'(oCOND_BUSY), 32'h1);
        drv(1'b1, 1'b0, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        check("flush_busy", 32'(oCOND_BUSY), 32'h0);
        check("flush_valid", 32'(oCOND_VALID), 32'h0);
        check("flush_pc", 32'(dut.pc_q), 32'h0);
        idle();
        push(1'b1, 1, "al_after_flush");
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_AL, 1'b0);
        idle();

        // Write at PC=0 must not underflow
        drv(1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 4'd0, 1'b0);
        check("pc_no_underflow", 32'(dut.pc_q), 32'h0);
        push(1'b1, 1, "ne_zero");
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_NE, 1'b0);
        idle();

        // Reset mid-WAIT drops the request
        drv(1'b0, 1'b1, 1'b1, 5'b11111, 1'b0, 4'd0, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 5'b0, 1'b0, 4'd0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, COND_AL, 1'b0);
        check("rst_wait_busy_pre", 32'(oCOND_BUSY), 32'h1);
        inRESET = 1'b0;
        drv(1'b1, 1'b0, 1'b1, 5'b10101, 1'b1, COND_AL, 1'b0);
        check("rst_wait_busy", 32'(oCOND_BUSY), 32'h0);
        check("rst_wait_flags", 32'(oFLAGS), 32'h0);
        check("rst_wait_ovf", 32'(oPEND_OVF), 32'h0);
        inRESET = 1'b1;
        repeat (4) idle();
        check("rst_wait_valid", 32'(oCOND_VALID), 32'h0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exe_flag_condition.md
EXE_FLAG_CONDITION -- requirements
Module: exe_flag_condition

Interface
REQ-001 SHALL have parameter P_PEND_MAX, default 3, meaning maximum outstanding flag-producing operations (counter saturates here).
REQ-002 SHALL have one clock and one reset: iCLOCK in 1, sole clock, rising edge; inRESET in 1, reset, synchronous, active-low.
REQ-003 SHALL have iFLUSH in 1, pipeline flush.
REQ-004 SHALL have iFLAG_PEND_SET in 1, an adder op that will write flags was issued this cycle.
REQ-005 SHALL have iFLAG_WR_VALID in 1, flag write strobe from the adder stage.
REQ-006 SHALL have iFLAG_WR_DATA in 5, flag write value {ZF,PF,OF,SF,CF}; PF is result bit 0, as the adder produces it.
REQ-007 SHALL have iCOND_VALID in 1, condition request.
REQ-008 SHALL have iCOND_CODE in 4, condition selector.
REQ-009 SHALL have oCOND_BUSY out 1, request not accepted this cycle.
REQ-010 SHALL have oCOND_VALID out 1, result valid.
REQ-011 SHALL have oCOND_RESULT out 1, condition true.
REQ-012 SHALL have iCOND_BUSY in 1, downstream stall.
REQ-013 SHALL have oFLAGS out 5, architectural flag register {ZF,PF,OF,SF,CF}.
REQ-014 SHALL have oPEND_OVF out 1, sticky pending-counter overflow.

Function
REQ-015 SHALL decode iCOND_CODE as follows:
- 0 AL=1; 1 EQ=ZF; 2 NE=!ZF; 3 CS=CF; 4 CC=!CF; 5 MI=SF; 6 PL=!SF; 7 VS=OF; 8 VC=!OF.
- 9 HI=CF&!ZF; 10 LS=!CF|ZF; 11 GE=SF==OF; 12 LT=SF!=OF.
- 13 GT=!ZF&(SF==OF); 14 LE=ZF|(SF!=OF); 15 PE=PF.
REQ-016 SHALL load oFLAGS from iFLAG_WR_DATA at the clock edge of any cycle with iFLAG_WR_VALID=1, regardless of FSM state.
REQ-017 SHALL keep pending count PC (2 bits) with these next-state rules:
- set only: +1; write only: -1; both or neither: unchanged.
- write at PC=0: stays 0, no underflow.
- set at PC=P_PEND_MAX with no write: stays P_PEND_MAX and sets oPEND_OVF.
REQ-018 SHALL run an FSM with states IDLE, WAIT, OUT; oCOND_BUSY=1 whenever state!=IDLE.
REQ-019 SHALL accept a request in IDLE when iCOND_VALID=1, latching iCOND_CODE.
REQ-020 SHALL define the "effective flags" of a cycle as iFLAG_WR_DATA when iFLAG_WR_VALID=1 that cycle, else oFLAGS (same-cycle bypass).
REQ-021 SHALL, at acceptance, evaluate with effective flags and go to OUT when next-PC=0 (1-cycle latency); otherwise go to WAIT.
REQ-022 SHALL, in WAIT, evaluate the latched code with effective flags in the cycle next-PC becomes 0, and go to OUT.
REQ-023 SHALL, in OUT, drive oCOND_VALID=1 with a stable oCOND_RESULT; return to IDLE when iCOND_BUSY=0; hold otherwise.
REQ-024 SHALL not accept a new request in the OUT exit cycle (no back-to-back); the minimum request spacing is 2 cycles.
REQ-025 SHALL, on iFLUSH=1, set state to IDLE, PC to 0, and oCOND_VALID to 0 next cycle; oFLAGS still accepts a same-cycle write; flush has priority over every transition.

Reset
REQ-026 SHALL, on inRESET=0 at a clock edge, set oFLAGS=5'h0, PC=0, state=IDLE, oCOND_VALID=0, oCOND_RESULT=0, and oPEND_OVF=0.
REQ-027 SHALL let reset override flush and all inputs; reset mid-WAIT or mid-OUT drops the request with no output.

Structure
REQ-028 SHALL place the condition-code constants (16 values) and flag bit indices (ZF=4, PF=3, OF=2, SF=1, CF=0) in the shared core package/header.
REQ-029 SHALL implement the condition decode as one combinational sub-module, exe_cond_eval (code, flags -> result), instantiated once.

Verification
REQ-030 SHALL cover: reset, then write flags 5'b10000 and request EQ with PC=0 -> oCOND_VALID one cycle later with result 1; then NE -> result 0.
REQ-031 SHALL cover: PEND_SET, next cycle request LT -> state WAIT; 2 cycles later write {SF=1,OF=0} -> result 1 valid the cycle after the write.
REQ-032 SHALL cover: PC=1 with request and write (5'b00001, CS) in the same cycle -> bypass, result 1 after 1 cycle; oFLAGS=5'b00001.
REQ-033 SHALL cover: 4 PEND_SETs with no write -> PC=3 and oPEND_OVF=1 sticky; 3 writes -> PC=0.
REQ-034 SHALL cover: in OUT with iCOND_BUSY=1 for 3 cycles -> oCOND_VALID and oCOND_RESULT held; a concurrent iCOND_VALID is ignored (oCOND_BUSY=1).
REQ-035 SHALL cover: iFLUSH during WAIT with PC=2 -> IDLE, PC=0, no oCOND_VALID; a subsequent AL request gives result 1 after 1 cycle.
